// File: rtl/cs_pkg.sv
// Shared types and constants for the count sequencer: FSM state encoding,
// terminal counter values and width helpers for the debounce/blink counters.
package cs_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } cs_state_t;

   localparam logic [15:0] TERM_UP = 16'h9999;
   localparam logic [15:0] TERM_DN = 16'h0000;

   localparam int unsigned DB_CYCLES_DEF = 250000;

   // Bits needed to hold the value n (never less than one bit).
   function automatic int unsigned cnt_w(input int unsigned n);
      return ($clog2(n + 1) > 0) ? $clog2(n + 1) : 1;
   endfunction

   localparam int unsigned DB_W = $clog2(DB_CYCLES_DEF + 1);

endpackage

// File: rtl/count_sequencer_btn_debounce.sv
// One push-button path: 2-FF synchronizer, stability debouncer and a
// one-clk press pulse on each accepted rising level.
module btn_debounce
   import cs_pkg::*;
#(
   parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
)
(
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   localparam int unsigned W = cnt_w(DB_CYCLES);
   localparam logic [W-1:0] LAST = W'(DB_CYCLES - 1);

   logic         sync1;
   logic         sync2;
   logic         level;
   logic [W-1:0] cnt;

   // cnt tracks consecutive samples that disagree with the accepted level;
   // the press pulse is registered on the same edge the new level is taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            level <= sync2;
            cnt   <= '0;
            press <= sync2;
         end else begin
            cnt <= cnt + W'(1);
         end
      end
   end

endmodule

// File: rtl/count_sequencer.sv
// Run controller for the BCD counter and 7-segment display path.
// Optional: define AUTO_RELOAD_EN to clear-and-continue at terminal instead of DONE.
module count_sequencer
   import cs_pkg::*;
#(
   parameter int unsigned DB_CYCLES   = 250000,
   parameter int unsigned BLINK_TICKS = 4
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic        btn_start,
   input  logic        btn_stop,
   input  logic        btn_dir,
   input  logic [15:0] count_bcd,
   output logic        cnt_enable,
   output logic        cnt_up_down,
   output logic        cnt_clear,
   output logic        blank,
   output logic [1:0]  state
);

   localparam int unsigned BW = cnt_w(BLINK_TICKS);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

   logic start_p;
   logic stop_p;
   logic dir_p;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_start),
      .press (start_p)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_stop (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_stop),
      .press (stop_p)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dir (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_dir),
      .press (dir_p)
   );

   cs_state_t      st_q, st_d;
   logic           up_q, up_d;
   logic           en_q, en_d;
   logic           clr_q, clr_d;
   logic           blank_q, blank_d;
   logic [BW-1:0]  blink_q, blink_d;
   logic           at_term;

   assign at_term = up_q ? (count_bcd == TERM_UP) : (count_bcd == TERM_DN);

   always_comb begin
      st_d    = st_q;
      up_d    = up_q;
      en_d    = 1'b0;
      clr_d   = 1'b0;
      blank_d = 1'b0;
      blink_d = '0;
      unique case (st_q)
         IDLE: begin
            if (dir_p) up_d = ~up_q;
            if (start_p && !stop_p) st_d = RUN;
         end
         RUN: begin
            if (stop_p) begin
               st_d = PAUSE;
            end else if (tick) begin
               if (!at_term) begin
                  en_d = 1'b1;
               end else begin
`ifdef AUTO_RELOAD_EN
                  clr_d = 1'b1;
`else
                  st_d    = DONE;
                  blank_d = 1'b1;
`endif
               end
            end
         end
         PAUSE: begin
            if (dir_p) up_d = ~up_q;
            if (stop_p) begin
               st_d  = IDLE;
               clr_d = 1'b1;
            end else if (start_p) begin
               st_d = RUN;
            end
         end
         DONE: begin
            blank_d = blank_q;
            blink_d = blink_q;
            if (stop_p || start_p) begin
               st_d    = IDLE;
               clr_d   = stop_p;
               blank_d = 1'b0;
               blink_d = '0;
            end else if (tick) begin
               if (blink_q == BLINK_LAST) begin
                  blank_d = ~blank_q;
                  blink_d = '0;
               end else begin
                  blink_d = blink_q + BW'(1);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q    <= IDLE;
         up_q    <= 1'b1;
         en_q    <= 1'b0;
         clr_q   <= 1'b0;
         blank_q <= 1'b0;
         blink_q <= '0;
      end else begin
         st_q    <= st_d;
         up_q    <= up_d;
         en_q    <= en_d;
         clr_q   <= clr_d;
         blank_q <= blank_d;
         blink_q <= blink_d;
      end
   end

   assign cnt_enable  = en_q;
   assign cnt_up_down = up_q;
   assign cnt_clear   = clr_q;
   assign blank       = blank_q;
   assign state       = st_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer: directed scenarios plus a
// randomized run, all compared against a behavioural model of the sequencer.
module tb_count_sequencer;

   localparam int unsigned DB = 4;
   localparam int unsigned BT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        tick;
   logic        btn_start;
   logic        btn_stop;
   logic        btn_dir;
   logic [15:0] count_bcd;
   logic        cnt_enable;
   logic        cnt_up_down;
   logic        cnt_clear;
   logic        blank;
   logic [1:0]  state;

   int checks   = 0;
   int failures = 0;

   count_sequencer #(.DB_CYCLES(DB), .BLINK_TICKS(BT)) dut (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .btn_start   (btn_start),
      .btn_stop    (btn_stop),
      .btn_dir     (btn_dir),
      .count_bcd   (count_bcd),
      .cnt_enable  (cnt_enable),
      .cnt_up_down (cnt_up_down),
      .cnt_clear   (cnt_clear),
      .blank       (blank),
      .state       (state)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural reference ----------------
   int m_state;
   bit m_up, m_en, m_clr, m_blank;
   int done_ticks;
   bit raw_hist[3][0:15];
   bit lvl[3];
   bit ev[3];

   function automatic int bcd2int(input logic [15:0] b);
      return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic logic [15:0] int2bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [5:0] mvec();
      logic [1:0] s;
      s = 2'(m_state);
      return {s, m_en, m_up, m_clr, m_blank};
   endfunction

   function automatic logic [5:0] dvec();
      return {state, cnt_enable, cnt_up_down, cnt_clear, blank};
   endfunction

   always @(posedge clk) begin
      bit st_p, sp_p, dr_p, term, all_diff;
      bit raw[3];
      if (rst) begin
         m_state = 0; m_up = 1; m_en = 0; m_clr = 0; m_blank = 0; done_ticks = 0;
         for (int b = 0; b < 3; b++) begin
            lvl[b] = 0; ev[b] = 0;
            for (int i = 0; i < 16; i++) raw_hist[b][i] = 0;
         end
      end else begin
         st_p = ev[0]; sp_p = ev[1]; dr_p = ev[2];
         term = m_up ? (bcd2int(count_bcd) == 9999) : (bcd2int(count_bcd) == 0);
         m_en = 0; m_clr = 0;
         case (m_state)
            0: begin
               if (dr_p) m_up = !m_up;
               if (st_p && !sp_p) m_state = 1;
            end
            1: begin
               if (sp_p) m_state = 2;
               else if (tick) begin
                  if (!term) m_en = 1;
                  else begin
`ifdef AUTO_RELOAD_EN
                     m_clr = 1;
`else
                     m_state = 3; done_ticks = 0;
`endif
                  end
               end
            end
            2: begin
               if (dr_p) m_up = !m_up;
               if (sp_p) begin m_state = 0; m_clr = 1; end
               else if (st_p) m_state = 1;
            end
            default: begin
               if (sp_p || st_p) begin m_state = 0; m_clr = sp_p; end
               else if (tick) done_ticks++;
            end
         endcase
         m_blank = (m_state == 3) && (((done_ticks / BT) % 2) == 0);
         // a button is accepted once DB consecutive synchronized samples disagree with its level
         raw[0] = btn_start; raw[1] = btn_stop; raw[2] = btn_dir;
         for (int b = 0; b < 3; b++) begin
            for (int i = 15; i > 0; i--) raw_hist[b][i] = raw_hist[b][i-1];
            raw_hist[b][0] = raw[b];
            all_diff = 1;
            for (int i = 2; i < 2 + DB; i++) if (raw_hist[b][i] == lvl[b]) all_diff = 0;
            ev[b] = 0;
            if (all_diff) begin lvl[b] = !lvl[b]; ev[b] = lvl[b]; end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic press_btn(input logic [2:0] mask, input int hold, input int gap, input bit ticks,
                            output int bad, output int clrs, output int ens);
      bad = 0; clrs = 0; ens = 0;
      for (int k = 0; k < hold + gap; k++) begin
         {btn_dir, btn_stop, btn_start} = (k < hold) ? mask : 3'b000;
         tick = ticks ? ($urandom_range(0, 3) == 0) : 1'b0;
         @(negedge clk);
         if (dvec() !== mvec()) bad++;
         clrs += int'(cnt_clear);
         ens  += int'(cnt_enable);
      end
      tick = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; tick = 1'b0; count_bcd = 16'h0042;
      {btn_dir, btn_stop, btn_start} = 3'b000;
      repeat (2) @(negedge clk);
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
      checks++; if (cnt_up_down !== 1'b1) begin failures++; $display("FAIL reset_dir got=%b exp=1", cnt_up_down); end
      checks++; if (blank !== 1'b0) begin failures++; $display("FAIL reset_blank got=%b exp=0", blank); end
      checks++; if (cnt_enable !== 1'b0) begin failures++; $display("FAIL reset_enable got=%b exp=0", cnt_enable); end
      checks++; if (cnt_clear !== 1'b0) begin failures++; $display("FAIL reset_clear got=%b exp=0", cnt_clear); end
      rst = 1'b0;
   endtask

   task automatic test_start_latency;
      int bad, clrs, ens;
      press_btn(3'b001, 3, 12, 1'b0, bad, clrs, ens);
      checks++; if (bad !== 0) begin failures++; $display("FAIL glitch_model got=%0d bad cycles exp=0", bad); end
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL glitch_state got=%0d exp=0", state); end
      btn_start = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 6) begin
            checks++; if (state !== 2'd0) begin failures++; $display("FAIL start_early got=%0d exp=0", state); end
         end
         if (k == 7) begin
            checks++; if (state !== 2'd1) begin failures++; $display("FAIL start_latency got=%0d exp=1", state); end
         end
      end
      press_btn(3'b000, 0, 10, 1'b0, bad, clrs, ens);
      count_bcd = 16'h0042;
      for (int n = 0; n < 3; n++) begin
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
         checks++; if (cnt_enable !== 1'b1) begin failures++; $display("FAIL tick_enable got=%b exp=1", cnt_enable); end
         @(negedge clk);
         checks++; if (cnt_enable !== 1'b0) begin failures++; $display("FAIL tick_width got=%b exp=0", cnt_enable); end
      end
      checks++; if (dvec() !== mvec()) begin failures++; $display("FAIL start_model got=%b exp=%b", dvec(), mvec()); end
   endtask

   task automatic test_pause_dir_clear;
      int bad, clrs, ens;
      press_btn(3'b010, 8, 10, 1'b1, bad, clrs, ens);
      checks++; if (bad !== 0 || state !== 2'd2) begin failures++; $display("FAIL run_stop got state=%0d bad=%0d exp state=2 bad=0", state, bad); end
      press_btn(3'b100, 8, 10, 1'b1, bad, clrs, ens);
      checks++; if (bad !== 0 || cnt_up_down !== 1'b0) begin failures++; $display("FAIL pause_dir got dir=%b bad=%0d exp dir=0 bad=0", cnt_up_down, bad); end
      press_btn(3'b010, 8, 10, 1'b1, bad, clrs, ens);
      checks++; if (bad !== 0 || state !== 2'd0) begin failures++; $display("FAIL pause_stop got state=%0d bad=%0d exp state=0 bad=0", state, bad); end
      checks++; if (clrs !== 1) begin failures++; $display("FAIL pause_clear got=%0d pulses exp=1", clrs); end
   endtask

   task automatic test_done;
      int bad, clrs, ens;
      press_btn(3'b100, 8, 10, 1'b0, bad, clrs, ens);
      checks++; if (bad !== 0 || cnt_up_down !== 1'b1) begin failures++; $display("FAIL idle_dir got dir=%b bad=%0d exp dir=1 bad=0", cnt_up_down, bad); end
      press_btn(3'b001, 8, 10, 1'b0, bad, clrs, ens);
      checks++; if (state !== 2'd1) begin failures++; $display("FAIL done_run got=%0d exp=1", state); end
      count_bcd = 16'h9999;
      tick = 1'b1; @(negedge clk); tick = 1'b0;
      checks++; if (cnt_enable !== 1'b0) begin failures++; $display("FAIL term_enable got=%b exp=0", cnt_enable); end
`ifdef AUTO_RELOAD_EN
      checks++; if (cnt_clear !== 1'b1 || state !== 2'd1) begin failures++; $display("FAIL reload got clr=%b state=%0d exp clr=1 state=1", cnt_clear, state); end
      @(negedge clk);
      checks++; if (cnt_clear !== 1'b0) begin failures++; $display("FAIL reload_width got=%b exp=0", cnt_clear); end
      press_btn(3'b010, 8, 10, 1'b0, bad, clrs, ens);
      press_btn(3'b010, 8, 10, 1'b0, bad, clrs, ens);
      checks++; if (state !== 2'd0 || clrs !== 1) begin failures++; $display("FAIL reload_exit got state=%0d clr=%0d exp state=0 clr=1", state, clrs); end
`else
      checks++; if (state !== 2'd3 || blank !== 1'b1) begin failures++; $display("FAIL done_entry got state=%0d blank=%b exp state=3 blank=1", state, blank); end
      tick = 1'b1; @(negedge clk); tick = 1'b0; @(negedge clk);
      checks++; if (blank !== 1'b1) begin failures++; $display("FAIL blink_hold got=%b exp=1", blank); end
      tick = 1'b1; @(negedge clk); tick = 1'b0;
      checks++; if (blank !== 1'b0) begin failures++; $display("FAIL blink_toggle got=%b exp=0", blank); end
      press_btn(3'b010, 8, 10, 1'b0, bad, clrs, ens);
      checks++; if (bad !== 0 || state !== 2'd0 || blank !== 1'b0) begin failures++; $display("FAIL done_stop got state=%0d blank=%b bad=%0d exp 0/0/0", state, blank, bad); end
      checks++; if (clrs !== 1) begin failures++; $display("FAIL done_stop_clear got=%0d exp=1", clrs); end
      press_btn(3'b100, 8, 10, 1'b0, bad, clrs, ens);
      count_bcd = 16'h0000;
      press_btn(3'b001, 8, 10, 1'b0, bad, clrs, ens);
      tick = 1'b1; @(negedge clk); tick = 1'b0;
      checks++; if (state !== 2'd3) begin failures++; $display("FAIL done_down got=%0d exp=3", state); end
      press_btn(3'b001, 8, 10, 1'b0, bad, clrs, ens);
      checks++; if (bad !== 0 || state !== 2'd0 || clrs !== 0) begin failures++; $display("FAIL done_start got state=%0d clr=%0d bad=%0d exp 0/0/0", state, clrs, bad); end
      press_btn(3'b100, 8, 10, 1'b0, bad, clrs, ens);
`endif
      checks++; if (cnt_up_down !== 1'b1 || dvec() !== mvec()) begin failures++; $display("FAIL done_final got=%b exp=%b", dvec(), mvec()); end
   endtask

   task automatic test_simultaneous;
      int bad, clrs, ens;
      count_bcd = 16'h0042;
      press_btn(3'b001, 8, 10, 1'b1, bad, clrs, ens);
      press_btn(3'b011, 8, 10, 1'b1, bad, clrs, ens);
      checks++; if (bad !== 0 || state !== 2'd2 || clrs !== 0) begin failures++; $display("FAIL sim_run got state=%0d clr=%0d bad=%0d exp 2/0/0", state, clrs, bad); end
      press_btn(3'b011, 8, 10, 1'b1, bad, clrs, ens);
      checks++; if (bad !== 0 || state !== 2'd0 || clrs !== 1) begin failures++; $display("FAIL sim_pause got state=%0d clr=%0d bad=%0d exp 0/1/0", state, clrs, bad); end
      press_btn(3'b101, 8, 10, 1'b1, bad, clrs, ens);
      checks++; if (bad !== 0 || state !== 2'd1 || cnt_up_down !== 1'b0) begin failures++; $display("FAIL sim_dir_start got state=%0d dir=%b exp state=1 dir=0", state, cnt_up_down); end
      press_btn(3'b010, 8, 10, 1'b1, bad, clrs, ens);
      press_btn(3'b010, 8, 10, 1'b1, bad, clrs, ens);
      press_btn(3'b100, 8, 10, 1'b1, bad, clrs, ens);
      checks++; if (bad !== 0 || dvec() !== mvec()) begin failures++; $display("FAIL sim_final got=%b exp=%b", dvec(), mvec()); end
   endtask

   task automatic test_held;
      int bad, clrs, ens;
      press_btn(3'b001, 8, 10, 1'b1, bad, clrs, ens);
      press_btn(3'b010, 40, 10, 1'b1, bad, clrs, ens);
      checks++; if (bad !== 0 || state !== 2'd2 || clrs !== 0) begin failures++; $display("FAIL held_stop got state=%0d clr=%0d bad=%0d exp 2/0/0", state, clrs, bad); end
      press_btn(3'b010, 8, 10, 1'b1, bad, clrs, ens);
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL held_exit got=%0d exp=0", state); end
   endtask

   task automatic test_random;
      logic [2:0] lv;
      lv = 3'b000;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 7) == 0) lv[$urandom_range(0, 2)] ^= 1'b1;
         {btn_dir, btn_stop, btn_start} = lv;
         tick = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 9) == 0) begin
            case ($urandom_range(0, 2))
               0: count_bcd = 16'h9999;
               1: count_bcd = 16'h0000;
               default: count_bcd = int2bcd(int'($urandom_range(1, 9998)));
            endcase
         end
         @(negedge clk);
         checks++;
         if (dvec() !== mvec()) begin
            failures++;
            $display("FAIL random cyc=%0d got=%b exp=%b", c, dvec(), mvec());
         end
      end
      tick = 1'b0;
   endtask

   task automatic test_reset_midrun;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (dvec() !== 6'b00_0_1_0_0) begin failures++; $display("FAIL midrun_reset got=%b exp=000100", dvec()); end
      rst = 1'b0;
      {btn_dir, btn_stop, btn_start} = 3'b000;
      repeat (4) @(negedge clk);
      checks++;
      if (dvec() !== mvec()) begin failures++; $display("FAIL post_reset got=%b exp=%b", dvec(), mvec()); end
   endtask

   initial begin
      test_reset;
      test_start_latency;
      test_pause_dir_clear;
      test_done;
      test_simultaneous;
      test_held;
      test_random;
      test_reset_midrun;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog got=timeout exp=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
